// File: rtl/sr_bank_writer_if.sv
// ---------------------------------------------------------------------------
// sr_bank_writer_if
// Groups the signals of sr_bank_writer: the control handshake with the master
// and the drive/readback lines of the SR flip-flop bank.
//   req       master -> writer  write request
//   target    master -> writer  desired Q pattern
//   busy      writer -> master  write in progress
//   done      writer -> master  one-cycle success pulse
//   err       writer -> master  one-cycle failure pulse
//   err_bits  writer -> master  mismatch mask, valid with err
//   s_out     writer -> bank    per-bit set pulses
//   r_out     writer -> bank    per-bit reset pulses
//   q_in      bank   -> writer  readback of the bank's Q outputs
// The master modport is the environment side (control master plus bank);
// the slave modport is the writer side.
// ---------------------------------------------------------------------------
interface sr_bank_writer_if #(
   parameter int unsigned Width = 8
) ();

   logic             req;
   logic [Width-1:0] target;
   logic             busy;
   logic             done;
   logic             err;
   logic [Width-1:0] err_bits;
   logic [Width-1:0] s_out;
   logic [Width-1:0] r_out;
   logic [Width-1:0] q_in;

   modport master (
      output req, target, q_in,
      input  busy, done, err, err_bits, s_out, r_out
   );

   modport slave (
      input  req, target, q_in,
      output busy, done, err, err_bits, s_out, r_out
   );

endinterface

// File: rtl/sr_bank_writer.sv
// ---------------------------------------------------------------------------
// sr_bank_writer
// Drives a bank of Width clocked SR flip-flops to a requested pattern using
// per-bit set/reset pulses, then reads Q back and retries up to MaxRetry
// extra times before reporting the mismatching bits. S and R are never
// asserted together on the same bit.
// Ports:
//   clk_i    rising-edge clock, shared with the SR bank
//   rst_n_i  asynchronous active-low reset
//   bus_io   sr_bank_writer_if.slave (handshake + bank drive/readback)
// All outputs are registered.
// ---------------------------------------------------------------------------
module sr_bank_writer #(
   parameter int unsigned Width       = 8,
   parameter int unsigned PulseCycles = 2,
   parameter int unsigned MaxRetry    = 2
) (
   input logic             clk_i,
   input logic             rst_n_i,
   sr_bank_writer_if.slave bus_io
);

   localparam int unsigned PulseW = (PulseCycles > 1) ? $clog2(PulseCycles) : 1;
   localparam int unsigned RetryW = (MaxRetry > 0) ? $clog2(MaxRetry + 1) : 1;

   typedef enum logic [1:0] {StIdle, StDrive, StSettle, StCheck} state_e;

   state_e            state_q, state_d;
   logic [PulseW-1:0] pulse_cnt_q, pulse_cnt_d;
   logic [RetryW-1:0] retry_q, retry_d;
   logic [Width-1:0]  tgt_q, tgt_d;
   logic [Width-1:0]  s_q, s_d;
   logic [Width-1:0]  r_q, r_d;
   logic [Width-1:0]  err_bits_q, err_bits_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic [Width-1:0]  accept_diff;
   logic [Width-1:0]  check_diff;
   logic              pulse_last;
   logic              retry_last;

   assign accept_diff = bus_io.target ^ bus_io.q_in;
   assign check_diff  = bus_io.q_in ^ tgt_q;
   assign pulse_last  = (pulse_cnt_q == PulseW'(PulseCycles - 1));
   assign retry_last  = (retry_q == RetryW'(MaxRetry));

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= StIdle;
         pulse_cnt_q <= '0;
         retry_q     <= '0;
         tgt_q       <= '0;
         s_q         <= '0;
         r_q         <= '0;
         err_bits_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pulse_cnt_q <= pulse_cnt_d;
         retry_q     <= retry_d;
         tgt_q       <= tgt_d;
         s_q         <= s_d;
         r_q         <= r_d;
         err_bits_q  <= err_bits_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            // A request whose target already matches completes without leaving IDLE.
            if (bus_io.req && (accept_diff != '0)) state_d = StDrive;
         end
         StDrive: begin
            if (pulse_last) state_d = StSettle;
         end
         StSettle: begin
            state_d = StCheck;
         end
         StCheck: begin
            if (check_diff == '0)  state_d = StIdle;
            else if (!retry_last)  state_d = StDrive;
            else                   state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Next values of the registered outputs and counters.
   always_comb begin
      pulse_cnt_d = pulse_cnt_q;
      retry_d     = retry_q;
      tgt_d       = tgt_q;
      s_d         = s_q;
      r_d         = r_q;
      err_bits_d  = '0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus_io.req) begin
               tgt_d = bus_io.target;
               if (accept_diff == '0) begin
                  done_d = 1'b1;
               end else begin
                  // diff & target and diff & ~target are disjoint, so S and R never overlap.
                  s_d         = accept_diff & bus_io.target;
                  r_d         = accept_diff & ~bus_io.target;
                  busy_d      = 1'b1;
                  pulse_cnt_d = '0;
                  retry_d     = '0;
               end
            end
         end
         StDrive: begin
            if (pulse_last) begin
               s_d = '0;
               r_d = '0;
            end else begin
               pulse_cnt_d = pulse_cnt_q + 1'b1;
            end
         end
         StSettle: begin
         end
         StCheck: begin
            if (check_diff == '0) begin
               done_d = 1'b1;
               busy_d = 1'b0;
            end else if (!retry_last) begin
               // Retry masks come from the live readback, not the original diff.
               retry_d     = retry_q + 1'b1;
               pulse_cnt_d = '0;
               s_d         = check_diff & tgt_q;
               r_d         = check_diff & ~tgt_q;
            end else begin
               err_d      = 1'b1;
               err_bits_d = check_diff;
               busy_d     = 1'b0;
            end
         end
         default: begin
         end
      endcase
   end

   assign bus_io.busy     = busy_q;
   assign bus_io.done     = done_q;
   assign bus_io.err      = err_q;
   assign bus_io.err_bits = err_bits_q;
   assign bus_io.s_out    = s_q;
   assign bus_io.r_out    = r_q;

endmodule

// File: tb/tb_sr_bank_writer.sv
// ---------------------------------------------------------------------------
// tb_sr_bank_writer
// Self-checking bench for sr_bank_writer (Width=8, PulseCycles=2, MaxRetry=2).
// A behavioural SR bank answers the writer; a stuck-at-0 mask can be applied
// to its readback. Latency k means DONE/ERR is high in the cycle after edge
// e_k, where e_0 is the acceptance edge.
// ---------------------------------------------------------------------------
module tb_sr_bank_writer;

   logic clk;
   logic rst_n;

   sr_bank_writer_if #(.Width(8)) bus ();

   sr_bank_writer #(
      .Width      (8),
      .PulseCycles(2),
      .MaxRetry   (2)
   ) dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural SR flip-flop bank with a preload port for setting up tests.
   logic [7:0] bank_q;
   logic [7:0] stuck0;
   logic       load;
   logic [7:0] load_val;

   always @(posedge clk) begin
      if (load) bank_q <= load_val;
      else      bank_q <= (bank_q | bus.s_out) & ~bus.r_out;
   end
   assign bus.q_in = bank_q & ~stuck0;

   int checks;
   int errors;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Observations collected while waiting for a request to finish.
   int         lat;
   int         drv;
   logic [7:0] s_seen;
   logic [7:0] r_seen;
   logic       overlap;
   logic       busy_seen;
   logic       got_done;
   logic       got_err;
   logic [7:0] eb;
   logic       busy_end;

   task automatic clear_stats();
      lat = -1; drv = 0; s_seen = '0; r_seen = '0; overlap = 1'b0;
      busy_seen = 1'b0; got_done = 1'b0; got_err = 1'b0; eb = '0; busy_end = 1'b1;
   endtask

   // Samples each cycle (on the falling edge) until DONE or ERR, bounded.
   task automatic wait_end(input int k0, input bit wait_edge);
      for (int k = k0; k < k0 + 60; k++) begin
         if (k != k0 || wait_edge) @(posedge clk);
         @(negedge clk);
         s_seen |= bus.s_out;
         r_seen |= bus.r_out;
         if ((bus.s_out & bus.r_out) != 8'h00) overlap = 1'b1;
         if ((bus.s_out | bus.r_out) != 8'h00) drv++;
         if (bus.done || bus.err) begin
            got_done = bus.done;
            got_err  = bus.err;
            eb       = bus.err_bits;
            busy_end = bus.busy;
            lat      = k;
            break;
         end
         busy_seen |= bus.busy;
      end
   endtask

   task automatic preload(input logic [7:0] q, input logic [7:0] stuck);
      @(negedge clk);
      stuck0   = stuck;
      load_val = q;
      load     = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
   endtask

   typedef struct {
      string      name;
      logic [7:0] init_q;
      logic [7:0] stuck;
      logic [7:0] target;
      logic [7:0] exp_s;
      logic [7:0] exp_r;
      int         exp_lat;
      int         exp_drv;
      logic       exp_busy;
      logic       exp_done;
      logic       exp_err;
      logic [7:0] exp_eb;
      logic [7:0] exp_q;
   } vec_t;

   vec_t vecs [5];

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      bus.req  = 1'b0;
      bus.target = 8'h00;
      stuck0   = 8'h00;
      load     = 1'b1;
      load_val = 8'h00;

      //         name      q      stuck  tgt    S      R      lat drv busy done err eb     q
      vecs[0] = '{"basic", 8'h00, 8'h00, 8'hA5, 8'hA5, 8'h00, 4,  2,  1'b1, 1'b1, 1'b0, 8'h00, 8'hA5};
      vecs[1] = '{"mixed", 8'h0F, 8'h00, 8'h3C, 8'h30, 8'h03, 4,  2,  1'b1, 1'b1, 1'b0, 8'h00, 8'h3C};
      vecs[2] = '{"noop",  8'h55, 8'h00, 8'h55, 8'h00, 8'h00, 0,  0,  1'b0, 1'b1, 1'b0, 8'h00, 8'h55};
      vecs[3] = '{"retry", 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 12, 6,  1'b1, 1'b0, 1'b1, 8'h01, 8'h00};
      vecs[4] = '{"clear", 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 4,  2,  1'b1, 1'b1, 1'b0, 8'h00, 8'h00};

      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'h0);
      check("rst_outs", {bus.done, bus.err, bus.err_bits, bus.s_out, bus.r_out}, 32'h0);
      rst_n = 1'b1;
      load  = 1'b0;
      @(negedge clk);
      check("post_rst_busy", 32'(bus.busy), 32'h0);

      // Table-driven requests.
      for (int i = 0; i < 5; i++) begin
         preload(vecs[i].init_q, vecs[i].stuck);
         @(negedge clk);
         bus.req    = 1'b1;
         bus.target = vecs[i].target;
         @(posedge clk);
         #1;
         bus.req    = 1'b0;
         bus.target = ~vecs[i].target;   // later target changes must be ignored
         clear_stats();
         wait_end(0, 1'b0);
         check({vecs[i].name, "_lat"},     32'(lat),       32'(vecs[i].exp_lat));
         check({vecs[i].name, "_s"},       32'(s_seen),    32'(vecs[i].exp_s));
         check({vecs[i].name, "_r"},       32'(r_seen),    32'(vecs[i].exp_r));
         check({vecs[i].name, "_drv"},     32'(drv),       32'(vecs[i].exp_drv));
         check({vecs[i].name, "_overlap"}, 32'(overlap),   32'h0);
         check({vecs[i].name, "_busy"},    32'(busy_seen), 32'(vecs[i].exp_busy));
         check({vecs[i].name, "_busyend"}, 32'(busy_end),  32'h0);
         check({vecs[i].name, "_done"},    32'(got_done),  32'(vecs[i].exp_done));
         check({vecs[i].name, "_err"},     32'(got_err),   32'(vecs[i].exp_err));
         check({vecs[i].name, "_eb"},      32'(eb),        32'(vecs[i].exp_eb));
         @(negedge clk);
         check({vecs[i].name, "_pulse"},   32'({bus.done, bus.err}), 32'h0);
         check({vecs[i].name, "_q"},       32'(bus.q_in),  32'(vecs[i].exp_q));
      end

      // Asynchronous reset in the middle of DRIVE.
      preload(8'h00, 8'h00);
      @(negedge clk);
      bus.req    = 1'b1;
      bus.target = 8'hF0;
      @(posedge clk);
      #1 bus.req = 1'b0;
      @(negedge clk);
      check("midrst_pre_s", 32'(bus.s_out), 32'hF0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_outs", {bus.done, bus.err, bus.err_bits, bus.s_out, bus.r_out}, 32'h0);
      check("midrst_busy", 32'(bus.busy), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      clear_stats();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         busy_seen |= bus.busy | bus.done | bus.err | (bus.s_out != 8'h00);
      end
      check("midrst_quiet", 32'(busy_seen), 32'h0);

      // Second REQ while busy is ignored; REQ held into the DONE cycle is accepted.
      preload(8'h00, 8'h00);
      @(negedge clk);
      bus.req    = 1'b1;
      bus.target = 8'h0F;
      @(posedge clk);
      #1 bus.target = 8'hFF;
      clear_stats();
      wait_end(0, 1'b0);
      check("prot_lat",  32'(lat),      32'd4);
      check("prot_done", 32'(got_done), 32'h1);
      check("prot_q",    32'(bus.q_in), 32'h0F);
      check("prot_s",    32'(s_seen),   32'h0F);
      @(posedge clk);
      #1 bus.req = 1'b0;
      @(negedge clk);
      check("b2b_busy", 32'(bus.busy), 32'h1);
      check("b2b_s",    32'(bus.s_out), 32'hF0);
      check("b2b_r",    32'(bus.r_out), 32'h00);
      clear_stats();
      wait_end(1, 1'b1);
      check("b2b_lat",  32'(lat),      32'd4);
      check("b2b_done", 32'(got_done), 32'h1);
      @(negedge clk);
      check("b2b_q",    32'(bus.q_in), 32'hFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
